mux_nx1_rr: RTL and testbench

Parametrised N-channel, W-bit registered stream multiplexer with valid/ready handshaking and fixed-select or round-robin channel selection. It is the next generation of the team's combinational 8x1 mux. It sits between multiple producer channels and a single consumer. It adds output buffering, backpressure, a fair arbitration mode and a channel tag on every output word.

---
 rtl/mux_nx1_rr.sv | 112 +++++++++++
 tb/tb_mux_nx1_rr.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_rr.sv
// +----------------------------------------------------------------------------+
// | mux_nx1_rr : N-channel registered stream mux, fixed-select or round-robin  |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module mux_nx1_rr #(
  parameter int N  = 8,
  parameter int W  = 8,
  parameter int SW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SW-1:0]     sl,
  input  logic [N-1:0]      it_vld,
  input  logic [N*W-1:0]    it_dat,
  output logic [N-1:0]      it_rdy,
  output logic              ot_vld,
  output logic [W-1:0]      ot_dat,
  output logic [SW-1:0]     ot_ch,
  input  logic              ot_rdy
);

  logic          ot_vld_q, ot_vld_d;
  logic [W-1:0]  ot_dat_q, ot_dat_d;
  logic [SW-1:0] ot_ch_q,  ot_ch_d;
  logic [SW-1:0] ptr_q,    ptr_d;

  logic          load;
  logic          gnt_vld;
  logic [SW-1:0] gnt_idx;
  logic [W-1:0]  sel_dat;
  logic          xfer;

  assign load = !ot_vld_q || ot_rdy;

  // Round-robin scan runs from the highest offset down so the nearest valid
  // channel to ptr is the last (winning) assignment.
  always_comb begin
    int t;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    t       = 0;
    if (!mode) begin
      for (int i = 0; i < N; i++) begin
        if (sl == SW'(i) && it_vld[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = SW'(i);
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        t = int'(ptr_q) + k;
        if (t >= N) t = t - N;
        for (int i = 0; i < N; i++) begin
          if (t == i && it_vld[i]) begin
            gnt_vld = 1'b1;
            gnt_idx = SW'(i);
          end
        end
      end
    end
  end

  always_comb begin
    sel_dat = '0;
    it_rdy  = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SW'(i)) sel_dat = it_dat[i*W +: W];
      it_rdy[i] = gnt_vld && load && (gnt_idx == SW'(i));
    end
  end

  assign xfer = gnt_vld && load;

  always_comb begin
    ot_vld_d = ot_vld_q;
    ot_dat_d = ot_dat_q;
    ot_ch_d  = ot_ch_q;
    ptr_d    = ptr_q;
    if (xfer) begin
      ot_vld_d = 1'b1;
      ot_dat_d = sel_dat;
      ot_ch_d  = gnt_idx;
      if (mode) ptr_d = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (ot_vld_q && ot_rdy) begin
      ot_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ot_vld_q <= 1'b0;
      ot_dat_q <= '0;
      ot_ch_q  <= '0;
      ptr_q    <= '0;
    end else begin
      ot_vld_q <= ot_vld_d;
      ot_dat_q <= ot_dat_d;
      ot_ch_q  <= ot_ch_d;
      ptr_q    <= ptr_d;
    end
  end

  assign ot_vld = ot_vld_q;
  assign ot_dat = ot_dat_q;
  assign ot_ch  = ot_ch_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_nx1_rr.sv
// +----------------------------------------------------------------------------+
// | tb_mux_nx1_rr : checks mux_nx1_rr (N=8 and N=6) against a behavioural model |
// | Revision      : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mux_nx1_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [2:0]  sl;
  logic [7:0]  vld;
  logic [63:0] dat;
  logic        ot_rdy;

  logic [7:0]  rdy0;
  logic        ov0;
  logic [7:0]  od0;
  logic [2:0]  oc0;
  logic [5:0]  rdy1;
  logic        ov1;
  logic [7:0]  od1;
  logic [2:0]  oc1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mux_nx1_rr #(.N(8), .W(8), .SW(3)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sl(sl),
    .it_vld(vld), .it_dat(dat), .it_rdy(rdy0),
    .ot_vld(ov0), .ot_dat(od0), .ot_ch(oc0), .ot_rdy(ot_rdy)
  );

  mux_nx1_rr #(.N(6), .W(8), .SW(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sl(sl),
    .it_vld(vld[5:0]), .it_dat(dat[47:0]), .it_rdy(rdy1),
    .ot_vld(ov1), .ot_dat(od1), .ot_ch(oc1), .ot_rdy(ot_rdy)
  );

  logic [7:0] a_rdy [2];
  logic       a_vld [2];
  logic [7:0] a_dat [2];
  logic [2:0] a_ch  [2];
  assign a_rdy[0] = rdy0;          assign a_rdy[1] = {2'b00, rdy1};
  assign a_vld[0] = ov0;           assign a_vld[1] = ov1;
  assign a_dat[0] = od0;           assign a_dat[1] = od1;
  assign a_ch[0]  = oc0;           assign a_ch[1]  = oc1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: which channel the rules pick, expressed with modulo arithmetic.
  function automatic void model_grant(input int n, input logic md, input logic [2:0] s,
                                      input logic [7:0] v, input int p,
                                      output bit gv, output int g);
    gv = 1'b0;
    g  = 0;
    if (!md) begin
      if (int'(s) < n && v[s]) begin
        gv = 1'b1;
        g  = int'(s);
      end
    end else begin
      for (int k = 0; k < n; k++) begin
        int c;
        c = (p + k) % n;
        if (!gv && v[c[2:0]]) begin
          gv = 1'b1;
          g  = c;
        end
      end
    end
  endfunction

  function automatic int nch(input int d);
    return (d == 0) ? 8 : 6;
  endfunction

  bit         m_vld [2];
  logic [7:0] m_dat [2];
  int         m_ch  [2];
  int         m_ptr [2];

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      bit gv;
      int g;
      if (!rst_n) begin
        m_vld[d] <= 1'b0;
        m_dat[d] <= 8'h00;
        m_ch[d]  <= 0;
        m_ptr[d] <= 0;
      end else begin
        model_grant(nch(d), mode, sl, vld, m_ptr[d], gv, g);
        if (gv && (!m_vld[d] || ot_rdy)) begin
          m_vld[d] <= 1'b1;
          m_dat[d] <= dat[g*8 +: 8];
          m_ch[d]  <= g;
          if (mode) m_ptr[d] <= (g + 1) % nch(d);
        end else if (m_vld[d] && ot_rdy) begin
          m_vld[d] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit gv;
      int g;
      int er;
      model_grant(nch(d), mode, sl, vld, m_ptr[d], gv, g);
      er = (gv && (!m_vld[d] || ot_rdy)) ? (1 << g) : 0;
      chk($sformatf("dut%0d it_rdy", d), int'(a_rdy[d]), er);
      chk($sformatf("dut%0d ot_vld", d), int'(a_vld[d]), int'(m_vld[d]));
      chk($sformatf("dut%0d ot_dat", d), int'(a_dat[d]), int'(m_dat[d]));
      chk($sformatf("dut%0d ot_ch", d),  int'(a_ch[d]),  m_ch[d]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dat(input logic [7:0] base);
    for (int i = 0; i < 8; i++) dat[i*8 +: 8] = base + 8'(i);
  endtask

  initial begin
    int exp_ch;
    rst_n = 1'b0; mode = 1'b0; sl = 3'd0; vld = 8'h00; ot_rdy = 1'b1;
    set_dat(8'h00);
    step(); step();
    rst_n = 1'b1;
    step(); step();
    chk("idle ot_vld", int'(ov0), 0);

    // Fixed select of channel 5
    mode = 1'b0; sl = 3'd5; vld = 8'hFF; set_dat(8'h10);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("fixed dat", int'(od0), 'h15);
      chk("fixed ch",  int'(oc0), 5);
      chk("fixed rdy", int'(rdy0), 'h20);
    end
    chk("fixed n6 ch", int'(oc1), 5);

    // Round-robin sweep from ptr 0
    mode = 1'b1; set_dat(8'hA0);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("rr sweep ch",  int'(oc0), c % 8);
      chk("rr sweep vld", int'(ov0), 1);
    end
    for (int c = 0; c < 4; c++) step();

    // Skip/wrap from ptr 6 with only channels 0 and 2 valid
    vld = 8'h05;
    for (int c = 0; c < 3; c++) begin
      step();
      exp_ch = (c == 1) ? 2 : 0;
      chk("rr skip ch", int'(oc0), exp_ch);
    end

    // Asynchronous reset while the output holds a word
    #2 rst_n = 1'b0;
    #1;
    chk("async rst vld", int'(ov0), 0);
    chk("async rst dat", int'(od0), 0);
    chk("async rst ch",  int'(oc0), 0);
    vld = 8'hFF; ot_rdy = 1'b0;
    step();
    rst_n = 1'b1;

    // Backpressure: first word held, pointer frozen
    step();
    chk("bp first ch",  int'(oc0), 0);
    chk("bp first dat", int'(od0), 'hA0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("bp hold ch",  int'(oc0), 0);
      chk("bp hold dat", int'(od0), 'hA0);
      chk("bp hold rdy", int'(rdy0), 0);
    end
    ot_rdy = 1'b1;
    #1 chk("bp release rdy", int'(rdy0), 'h02);
    step();
    chk("bp next ch",  int'(oc0), 1);
    chk("bp next dat", int'(od0), 'hA1);

    // Out-of-range select on the 6-channel instance, then switch mode
    mode = 1'b0; sl = 3'd7;
    #1 chk("oor rdy", int'(rdy1), 0);
    step();
    chk("oor drained", int'(ov1), 0);
    chk("oor n8 ch", int'(oc0), 7);
    mode = 1'b1;
    #1 chk("switch rdy", int'(rdy1), 'h04);
    step();
    chk("switch ch",  int'(oc1), 2);
    chk("switch dat", int'(od1), 'hA2);

    // Valid drops: output drains
    vld = 8'h00;
    step(); step();
    chk("drain vld", int'(ov0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
